ps2_vp_keyboard: RTL and testbench



---
 rtl/ps2_vp_keyboard.sv | 237 +++++++++++++++++++++++
 tb/tb_ps2_vp_keyboard.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_vp_keyboard.sv
// PS/2 set-2 keyboard receiver presenting a pressed-key table as the Videopac 6x8 active-low matrix.
// Optional build macro PS2_PARITY_CHECK_EN: drop bad-parity frames instead of accepting them.
module ps2_vp_keyboard #(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic        clk_i,
    input  logic        res_n_i,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    input  logic [6:1]  keyb_dec_i,
    output logic [14:7] keyb_enc_o,
    output logic [12:1] keyb_f_o,
    output logic [7:0]  scan_code_o,
    output logic        scan_valid_o,
    output logic        released_o,
    output logic        extended_o,
    output logic        parity_err_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] RX_IDLE   = 4'd0;
    localparam logic [3:0] RX_PARITY = 4'd9;
    localparam logic [3:0] RX_STOP   = 4'd10;

    localparam logic [7:0] CODE_REL = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;

    logic          ps2_clk_meta_reg, ps2_clk_sync_reg, ps2_clk_prev_reg;
    logic          ps2_data_meta_reg, ps2_data_sync_reg;
    logic [3:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          parity_reg;
    logic [TW-1:0] timer_reg;
    logic [7:0]    scan_code_reg;
    logic          scan_valid_reg, parity_err_reg, apply_reg;
    logic          released_reg, extended_reg;
    logic          pend_rel_reg, pend_ext_reg;
    logic [47:0]   key_reg;
    logic [12:1]   f_reg;

    logic          fall_edge, frame_ok, frame_accept, parity_bad;
    logic [6:0]    km;
    logic [3:0]    fm;
    logic          key_hit, f_hit;

    // Returns {hit, row*8+col} for the matrix position of a set-2 code.
    function automatic logic [6:0] key_map(input logic [7:0] code);
        case (code)
            8'h45, 8'h70: key_map = {1'b1, 6'd0};
            8'h16, 8'h69: key_map = {1'b1, 6'd1};
            8'h1E, 8'h72: key_map = {1'b1, 6'd2};
            8'h26, 8'h7A: key_map = {1'b1, 6'd3};
            8'h25, 8'h6B: key_map = {1'b1, 6'd4};
            8'h2E, 8'h73: key_map = {1'b1, 6'd5};
            8'h36, 8'h74: key_map = {1'b1, 6'd6};
            8'h3D, 8'h6C: key_map = {1'b1, 6'd7};
            8'h3E, 8'h75: key_map = {1'b1, 6'd8};
            8'h46, 8'h7D: key_map = {1'b1, 6'd9};
            8'h29:        key_map = {1'b1, 6'd12};
            8'h4A:        key_map = {1'b1, 6'd13};
            8'h4B:        key_map = {1'b1, 6'd14};
            8'h4D:        key_map = {1'b1, 6'd15};
            8'h79:        key_map = {1'b1, 6'd16};
            8'h1D:        key_map = {1'b1, 6'd17};
            8'h24:        key_map = {1'b1, 6'd18};
            8'h2D:        key_map = {1'b1, 6'd19};
            8'h2C:        key_map = {1'b1, 6'd20};
            8'h3C:        key_map = {1'b1, 6'd21};
            8'h43:        key_map = {1'b1, 6'd22};
            8'h44:        key_map = {1'b1, 6'd23};
            8'h15:        key_map = {1'b1, 6'd24};
            8'h1B:        key_map = {1'b1, 6'd25};
            8'h23:        key_map = {1'b1, 6'd26};
            8'h2B:        key_map = {1'b1, 6'd27};
            8'h34:        key_map = {1'b1, 6'd28};
            8'h33:        key_map = {1'b1, 6'd29};
            8'h3B:        key_map = {1'b1, 6'd30};
            8'h42:        key_map = {1'b1, 6'd31};
            8'h1C:        key_map = {1'b1, 6'd32};
            8'h1A:        key_map = {1'b1, 6'd33};
            8'h22:        key_map = {1'b1, 6'd34};
            8'h21:        key_map = {1'b1, 6'd35};
            8'h2A:        key_map = {1'b1, 6'd36};
            8'h32:        key_map = {1'b1, 6'd37};
            8'h3A:        key_map = {1'b1, 6'd38};
            8'h49:        key_map = {1'b1, 6'd39};
            8'h7B, 8'h4E: key_map = {1'b1, 6'd40};
            8'h7C:        key_map = {1'b1, 6'd41};
            8'h55:        key_map = {1'b1, 6'd43};
            8'h35:        key_map = {1'b1, 6'd44};
            8'h76:        key_map = {1'b1, 6'd45};
            8'h66:        key_map = {1'b1, 6'd46};
            8'h5A:        key_map = {1'b1, 6'd47};
            default:      key_map = 7'd0;
        endcase
    endfunction

    function automatic logic [3:0] f_map(input logic [7:0] code);
        case (code)
            8'h05:   f_map = 4'd1;
            8'h06:   f_map = 4'd2;
            8'h04:   f_map = 4'd3;
            8'h0C:   f_map = 4'd4;
            8'h03:   f_map = 4'd5;
            8'h0B:   f_map = 4'd6;
            8'h83:   f_map = 4'd7;
            8'h0A:   f_map = 4'd8;
            8'h01:   f_map = 4'd9;
            8'h09:   f_map = 4'd10;
            8'h78:   f_map = 4'd11;
            8'h07:   f_map = 4'd12;
            default: f_map = 4'd0;
        endcase
    endfunction

    assign fall_edge  = ps2_clk_prev_reg & ~ps2_clk_sync_reg;
    assign frame_ok   = fall_edge && (bit_cnt_reg == RX_STOP) && ps2_data_sync_reg;
    assign parity_bad = ~^{shift_reg, parity_reg};
`ifdef PS2_PARITY_CHECK_EN
    assign frame_accept = frame_ok && !parity_bad;
`else
    assign frame_accept = frame_ok;
`endif

    // Extended codes leave the matrix alone except keypad ENTER (E0 5A).
    always_comb begin
        km      = key_map(scan_code_reg);
        fm      = f_map(scan_code_reg);
        key_hit = km[6] && (!extended_reg || scan_code_reg == 8'h5A);
        f_hit   = (fm != 4'd0) && !extended_reg;
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            ps2_clk_meta_reg  <= 1'b1;
            ps2_clk_sync_reg  <= 1'b1;
            ps2_clk_prev_reg  <= 1'b1;
            ps2_data_meta_reg <= 1'b1;
            ps2_data_sync_reg <= 1'b1;
            bit_cnt_reg       <= RX_IDLE;
            shift_reg         <= 8'h00;
            parity_reg        <= 1'b0;
            timer_reg         <= '0;
            scan_code_reg     <= 8'h00;
            scan_valid_reg    <= 1'b0;
            parity_err_reg    <= 1'b0;
            apply_reg         <= 1'b0;
            released_reg      <= 1'b0;
            extended_reg      <= 1'b0;
            pend_rel_reg      <= 1'b0;
            pend_ext_reg      <= 1'b0;
            key_reg           <= '0;
            f_reg             <= '0;
        end else begin
            ps2_clk_meta_reg  <= ps2_clk_i;
            ps2_clk_sync_reg  <= ps2_clk_meta_reg;
            ps2_clk_prev_reg  <= ps2_clk_sync_reg;
            ps2_data_meta_reg <= ps2_data_i;
            ps2_data_sync_reg <= ps2_data_meta_reg;
            scan_valid_reg    <= 1'b0;
            parity_err_reg    <= 1'b0;
            apply_reg         <= 1'b0;

            if (fall_edge) begin
                timer_reg <= '0;
                case (bit_cnt_reg)
                    RX_IDLE: begin
                        if (!ps2_data_sync_reg)
                            bit_cnt_reg <= 4'd1;
                    end
                    RX_PARITY: begin
                        parity_reg  <= ps2_data_sync_reg;
                        bit_cnt_reg <= RX_STOP;
                    end
                    RX_STOP: bit_cnt_reg <= RX_IDLE;
                    default: begin
                        shift_reg   <= {ps2_data_sync_reg, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    end
                endcase
            end else if (bit_cnt_reg != RX_IDLE) begin
                if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt_reg <= RX_IDLE;
                    timer_reg   <= '0;
                end else begin
                    timer_reg <= timer_reg + 1'b1;
                end
            end

            if (frame_ok)
                parity_err_reg <= parity_bad;

            if (frame_accept) begin
                scan_valid_reg <= 1'b1;
                scan_code_reg  <= shift_reg;
                if (shift_reg == CODE_REL) begin
                    pend_rel_reg <= 1'b1;
                end else if (shift_reg == CODE_EXT) begin
                    pend_ext_reg <= 1'b1;
                end else begin
                    released_reg <= pend_rel_reg;
                    extended_reg <= pend_ext_reg;
                    pend_rel_reg <= 1'b0;
                    pend_ext_reg <= 1'b0;
                    apply_reg    <= 1'b1;
                end
            end

            // Table update trails the strobe by one cycle, using the registered code and flags.
            if (apply_reg) begin
                if (key_hit)
                    key_reg[km[5:0]] <= !released_reg;
                if (f_hit) begin
                    for (int i = 1; i <= 12; i++)
                        if (fm == 4'(i))
                            f_reg[i] <= !released_reg;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_col
            assign keyb_enc_o[gi+7] = ~|(~keyb_dec_i & {key_reg[40+gi], key_reg[32+gi], key_reg[24+gi],
                                                        key_reg[16+gi], key_reg[8+gi],  key_reg[gi]});
        end
    endgenerate

    assign keyb_f_o     = f_reg;
    assign scan_code_o  = scan_code_reg;
    assign scan_valid_o = scan_valid_reg;
    assign released_o   = released_reg;
    assign extended_o   = extended_reg;
    assign parity_err_o = parity_err_reg;

endmodule

// File: tb/tb_ps2_vp_keyboard.sv
// Self-checking bench for ps2_vp_keyboard: directed scenarios plus randomized frames against a key-table model.
module tb_ps2_vp_keyboard;
    localparam int TMO  = 300;
    localparam int HALF = 10;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [6:1]  keyb_dec = 6'b111111;
    logic [14:7] keyb_enc;
    logic [12:1] keyb_f;
    logic [7:0]  scan_code;
    logic        scan_valid, released, extended, parity_err;

    int checks = 0;
    int failures = 0;

    ps2_vp_keyboard #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .res_n_i(res_n), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
        .keyb_dec_i(keyb_dec), .keyb_enc_o(keyb_enc), .keyb_f_o(keyb_f),
        .scan_code_o(scan_code), .scan_valid_o(scan_valid), .released_o(released),
        .extended_o(extended), .parity_err_o(parity_err)
    );

    always #5 clk = ~clk;

    int         valid_cnt = 0;
    int         perr_cnt = 0;
    logic [7:0] cap_code = 8'h00;
    logic       cap_rel = 1'b0, cap_ext = 1'b0;

    always @(negedge clk) begin
        if (res_n && scan_valid) begin
            valid_cnt++;
            cap_code = scan_code;
            cap_rel  = released;
            cap_ext  = extended;
        end
        if (res_n && parity_err)
            perr_cnt++;
    end

    // Model: matrix legend table in set-2 codes (primary and keypad alternate), F-key codes, pressed state.
    logic [7:0]  tbl_a [0:5][0:7];
    logic [7:0]  tbl_b [0:5][0:7];
    logic [7:0]  fcode [1:12];
    logic        model_key [0:5][0:7];
    logic [12:1] model_f;
    logic        pend_rel, pend_ext, exp_rel, exp_ext;

    task automatic init_tables();
        tbl_a[0] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};
        tbl_b[0] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C};
        tbl_a[1] = '{8'h3E, 8'h46, 8'h00, 8'h00, 8'h29, 8'h4A, 8'h4B, 8'h4D};
        tbl_b[1] = '{8'h75, 8'h7D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl_a[2] = '{8'h79, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h3C, 8'h43, 8'h44};
        tbl_a[3] = '{8'h15, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
        tbl_a[4] = '{8'h1C, 8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h3A, 8'h49};
        tbl_a[5] = '{8'h7B, 8'h7C, 8'h00, 8'h55, 8'h35, 8'h76, 8'h66, 8'h5A};
        tbl_b[5] = '{8'h4E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int r = 2; r <= 4; r++)
            for (int c = 0; c < 8; c++)
                tbl_b[r][c] = 8'h00;
        fcode = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
    endtask

    task automatic model_clear();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 8; c++)
                model_key[r][c] = 1'b0;
        model_f = '0;
        pend_rel = 1'b0; pend_ext = 1'b0; exp_rel = 1'b0; exp_ext = 1'b0;
    endtask

    task automatic model_apply(input logic [7:0] code);
        if (code == 8'hF0) pend_rel = 1'b1;
        else if (code == 8'hE0) pend_ext = 1'b1;
        else begin
            exp_rel = pend_rel;
            exp_ext = pend_ext;
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 8; c++)
                    if ((tbl_a[r][c] == code || tbl_b[r][c] == code) && (!pend_ext || code == 8'h5A))
                        model_key[r][c] = !pend_rel;
            for (int f = 1; f <= 12; f++)
                if (!pend_ext && fcode[f] == code)
                    model_f[f] = !pend_rel;
            pend_rel = 1'b0;
            pend_ext = 1'b0;
        end
    endtask

    function automatic logic [7:0] model_enc(input logic [6:1] dec);
        logic [7:0] e;
        e = 8'hFF;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 8; c++)
                if (!dec[r+1] && model_key[r][c])
                    e[c] = 1'b0;
        return e;
    endfunction

    // Drives one 11-bit frame; cut_after >= 0 abandons it after that bit and idles for cut_wait cycles.
    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                              input int cut_after, input int cut_wait);
        logic [10:0] bits;
        bits = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
            if (i == cut_after) begin
                ps2_data = 1'b1;
                repeat (cut_wait) @(negedge clk);
                return;
            end
        end
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        if (!bad_stop) begin
`ifdef PS2_PARITY_CHECK_EN
            if (!bad_par) model_apply(code);
`else
            model_apply(code);
`endif
        end
    endtask

    task automatic key(input logic [7:0] code);
        send_frame(code, 1'b0, 1'b0, -1, 0);
    endtask

    task automatic do_reset();
        res_n = 1'b0;
        repeat (3) @(negedge clk);
        model_clear();
        res_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        for (int r = 0; r < 6; r++) begin
            keyb_dec = ~(6'd1 << r);
            #1;
            checks++;
            if (keyb_enc !== 8'hFF) begin
                failures++; $display("FAIL reset_enc row%0d: got %h expected ff", r, keyb_enc);
            end
        end
        keyb_dec = 6'b000000; #1;
        checks++;
        if ({keyb_enc, keyb_f, scan_code, scan_valid, released, extended, parity_err} !== 32'hFF00_0000) begin
            failures++;
            $display("FAIL reset_state: got enc=%h f=%h code=%h v=%b r=%b e=%b p=%b expected ff/000/00/0000",
                     keyb_enc, keyb_f, scan_code, scan_valid, released, extended, parity_err);
        end
        keyb_dec = 6'b111111;
    endtask

    task automatic test_fkey();
        int v0, p0;
        v0 = valid_cnt; p0 = perr_cnt;
        send_frame(8'h04, 1'b1, 1'b0, -1, 0);
        checks++;
`ifdef PS2_PARITY_CHECK_EN
        if (valid_cnt != v0 || perr_cnt != p0 + 1 || keyb_f !== 12'h000) begin
            failures++; $display("FAIL fkey_badpar: strobes=%0d perr=%0d f=%h expected 0/1/000", valid_cnt - v0, perr_cnt - p0, keyb_f);
        end
        key(8'h04);
`else
        if (valid_cnt != v0 + 1 || cap_code !== 8'h04 || perr_cnt != p0 + 1 || keyb_f !== 12'h004) begin
            failures++; $display("FAIL fkey_press: strobes=%0d code=%h perr=%0d f=%h expected 1/04/1/004", valid_cnt - v0, cap_code, perr_cnt - p0, keyb_f);
        end
`endif
        key(8'hF0); key(8'h04);
        checks++;
        if (cap_code !== 8'h04 || cap_rel !== 1'b1 || cap_ext !== 1'b0 || keyb_f !== 12'h000) begin
            failures++; $display("FAIL fkey_release: code=%h rel=%b ext=%b f=%h expected 04/1/0/000", cap_code, cap_rel, cap_ext, keyb_f);
        end
    endtask

    task automatic test_letter();
        logic [6:1] decs [3];
        logic [7:0] exps [3];
        decs = '{6'b101111, 6'b111110, 6'b001111};
        exps = '{8'hFE, 8'hFF, 8'hFE};
        key(8'h1C);
        for (int i = 0; i < 3; i++) begin
            keyb_dec = decs[i]; #1;
            checks++;
            if (keyb_enc !== exps[i]) begin
                failures++; $display("FAIL letter_a dec=%b: got %h expected %h", decs[i], keyb_enc, exps[i]);
            end
        end
        key(8'hF0); key(8'h1C);
        keyb_dec = 6'b101111; #1;
        checks++;
        if (keyb_enc !== 8'hFF) begin
            failures++; $display("FAIL letter_a_release: got %h expected ff", keyb_enc);
        end
    endtask

    task automatic test_held();
        logic [7:0] codes [3];
        logic [7:0] exps [3];
        codes = '{8'h76, 8'h5A, 8'h66};
        exps  = '{8'h3F, 8'hBF, 8'hFF};
        key(8'h76); key(8'h5A); key(8'h66);
        keyb_dec = 6'b011111; #1;
        checks++;
        if (keyb_enc !== 8'h1F) begin
            failures++; $display("FAIL held_three: got %h expected 1f", keyb_enc);
        end
        for (int i = 0; i < 3; i++) begin
            key(8'hF0); key(codes[i]);
            checks++;
            if (keyb_enc !== exps[i]) begin
                failures++; $display("FAIL held_release %h: got %h expected %h", codes[i], keyb_enc, exps[i]);
            end
        end
    endtask

    task automatic test_errors();
        int v0;
        v0 = valid_cnt;
        send_frame(8'h2C, 1'b0, 1'b1, -1, 0);
        checks++;
        if (valid_cnt != v0) begin
            failures++; $display("FAIL bad_stop: strobes=%0d expected 0", valid_cnt - v0);
        end
        send_frame(8'h2C, 1'b0, 1'b0, 4, TMO + 100);
        checks++;
        if (valid_cnt != v0) begin
            failures++; $display("FAIL timeout: strobes=%0d expected 0", valid_cnt - v0);
        end
        key(8'h2C);
        keyb_dec = 6'b111011; #1;
        checks++;
        if (valid_cnt != v0 + 1 || cap_code !== 8'h2C || keyb_enc !== 8'hEF) begin
            failures++; $display("FAIL recover: strobes=%0d code=%h enc=%h expected 1/2c/ef", valid_cnt - v0, cap_code, keyb_enc);
        end
        key(8'hF0); key(8'h2C);
    endtask

    task automatic test_extended();
        key(8'hE0); key(8'h5A);
        keyb_dec = 6'b011111; #1;
        checks++;
        if (cap_ext !== 1'b1 || cap_rel !== 1'b0 || keyb_enc !== 8'h7F) begin
            failures++; $display("FAIL ext_enter: ext=%b rel=%b enc=%h expected 1/0/7f", cap_ext, cap_rel, keyb_enc);
        end
        key(8'hE0); key(8'hF0); key(8'h5A);
        checks++;
        if (cap_ext !== 1'b1 || cap_rel !== 1'b1 || keyb_enc !== 8'hFF) begin
            failures++; $display("FAIL ext_enter_release: ext=%b rel=%b enc=%h expected 1/1/ff", cap_ext, cap_rel, keyb_enc);
        end
        key(8'hE0); key(8'h75);
        keyb_dec = 6'b111101; #1;
        checks++;
        if (cap_ext !== 1'b1 || cap_code !== 8'h75 || keyb_enc !== 8'hFF) begin
            failures++; $display("FAIL ext_75: ext=%b code=%h enc=%h expected 1/75/ff", cap_ext, cap_code, keyb_enc);
        end
        key(8'h75);
        checks++;
        if (cap_ext !== 1'b0 || keyb_enc !== 8'hFE) begin
            failures++; $display("FAIL plain_75: ext=%b enc=%h expected 0/fe", cap_ext, keyb_enc);
        end
        key(8'hF0); key(8'h75);
    endtask

    task automatic test_reset_midframe();
        key(8'h1C);
        send_frame(8'h2C, 1'b0, 1'b0, 5, 3);
        do_reset();
        keyb_dec = 6'b101111; #1;
        checks++;
        if (keyb_enc !== 8'hFF || scan_code !== 8'h00) begin
            failures++; $display("FAIL midframe_reset: enc=%h code=%h expected ff/00", keyb_enc, scan_code);
        end
        key(8'h1C);
        checks++;
        if (cap_code !== 8'h1C || keyb_enc !== 8'hFE) begin
            failures++; $display("FAIL after_reset_frame: code=%h enc=%h expected 1c/fe", cap_code, keyb_enc);
        end
        key(8'hF0); key(8'h1C);
    endtask

    task automatic test_random();
        logic [7:0] pool [22];
        logic [7:0] code;
        logic [6:1] dec;
        logic [7:0] want;
        bit         bad;
        int         v0, p0, want_v;
        pool = '{8'h1C, 8'h16, 8'h69, 8'h29, 8'h7B, 8'h4E, 8'h35, 8'h5A, 8'h66, 8'h76, 8'h05,
                 8'h04, 8'h07, 8'h83, 8'h75, 8'h0D, 8'h58, 8'h49, 8'hF0, 8'hF0, 8'hE0, 8'h55};
        for (int n = 0; n < 60; n++) begin
            code = pool[$urandom_range(21, 0)];
            bad  = ($urandom_range(5, 0) == 0);
            v0 = valid_cnt; p0 = perr_cnt;
            send_frame(code, bad, 1'b0, -1, 0);
`ifdef PS2_PARITY_CHECK_EN
            want_v = bad ? 0 : 1;
`else
            want_v = 1;
`endif
            checks++;
            if (valid_cnt != v0 + want_v || perr_cnt != p0 + int'(bad)) begin
                failures++; $display("FAIL rand%0d strobes code=%h: valid=%0d perr=%0d expected %0d/%0d", n, code, valid_cnt - v0, perr_cnt - p0, want_v, int'(bad));
            end
            if (want_v == 1) begin
                checks++;
                if (cap_code !== code || cap_rel !== exp_rel || cap_ext !== exp_ext) begin
                    failures++; $display("FAIL rand%0d flags: code=%h rel=%b ext=%b expected %h/%b/%b", n, cap_code, cap_rel, cap_ext, code, exp_rel, exp_ext);
                end
            end
            dec = 6'($urandom);
            keyb_dec = dec; #1;
            want = model_enc(dec);
            checks++;
            if (keyb_enc !== want || keyb_f !== model_f) begin
                failures++; $display("FAIL rand%0d matrix dec=%b: enc=%h f=%h expected %h/%h", n, dec, keyb_enc, keyb_f, want, model_f);
            end
        end
    endtask

    initial begin
        init_tables();
        model_clear();
        test_reset();
        test_fkey();
        test_letter();
        test_held();
        test_errors();
        test_extended();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
